mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single memory port between two requesters: requester 0 is the processor datapath (address/data-out/write-enable path); requester 1 is the program loader / IO port.
- Grants one requester per transaction and sequences the memory access through address, read-latency wait and acknowledge phases.
- Returns read data with a one-cycle ack pulse. Sits between the requesters and the memory, so a requester stalls until it receives its ack.

Parameters:
DATA_W, 16, width of data words
ADDR_W, 8, width of memory address
RD_LAT, 1, memory read latency in cycles (0..7); mem_rdata valid RD_LAT cycles after the address cycle

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req0  in  1  requester 0 (processor) transaction request, held until ack0
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
we0  in  1  requester 0 write (1) / read (0)
req1  in  1  requester 1 (loader) transaction request, held until ack1
addr1  in  ADDR_W  requester 1 address
wdata1  in  DATA_W  requester 1 write data
we1  in  1  requester 1 write (1) / read (0)
gnt0  out  1  requester 0 owns bus (ACCESS through ACK)
gnt1  out  1  requester 1 owns bus
ack0  out  1  one-cycle completion pulse to requester 0
ack1  out  1  one-cycle completion pulse to requester 1
rdata  out  DATA_W  captured read data, valid while ack0/ack1 high for a read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write strobe
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock `clock`; reset is synchronous and active-high (`reset`).
- Reset: state=IDLE, prio=0 (requester 0 favoured), latched addr/wdata/we=0, rdata=0. All outputs low or zero.
- Reset asserted mid-transaction: IDLE on the next edge. No ack is issued, mem_we drops, and the aborted transaction is lost.
- FSM states: IDLE, ACCESS, WAIT, ACK.
- IDLE:
  - Single request: grant it.
  - Both requests: grant the requester selected by prio.
  - On grant, latch that requester's addr/wdata/we and its owner id, then go to ACCESS.
  - No request: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - gnt of the owner high; mem_addr=latched addr; mem_wdata=latched wdata; mem_we=latched we.
  - Write: go to ACK.
  - Read with RD_LAT=0: capture mem_rdata into rdata this cycle, then go to ACK.
  - Read with RD_LAT>0: load down-counter with RD_LAT, then go to WAIT.
- WAIT:
  - mem_we=0; mem_addr holds the latched addr; counter decrements each cycle.
  - In the cycle the counter reads 1, capture mem_rdata into rdata and go to ACK.
  - WAIT lasts RD_LAT cycles.
- ACK (1 cycle):
  - Owner's ack high; gnt stays high; rdata stable.
  - prio set to the other requester; go to IDLE.
- Latency from the IDLE grant cycle t:
  - Write: ACCESS at t+1, ack at t+2.
  - Read: ack at t+2+RD_LAT.
  - Each IDLE grant costs exactly one cycle, so back-to-back transactions are spaced 3+ cycles (writes) apart.
- mem_addr and mem_wdata hold the last latched values outside ACCESS. mem_we is high only in ACCESS.
- Requester inputs are sampled only at the IDLE grant. Changes afterward, including dropping req, do not affect the transaction in flight, and the ack is still issued.
- gnt0 and gnt1 are never simultaneously high. ack fires only to the owner.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1... A single continuous requester is granted every transaction.
- rdata after a write ack holds the previous read value.

Test Plan:
- Reset, then req0 write addr=0x12 wdata=0xBEEF -> mem_we=1 for exactly one cycle with mem_addr=0x12 and mem_wdata=0xBEEF; ack0 pulses 2 cycles after the grant; gnt1 never high.
- RD_LAT=1, memory model returns 0x00A5 at addr 0x34, req1 read -> ack1 at grant+3 with rdata=0x00A5; mem_we stays 0.
- req0 and req1 asserted together from reset, held continuously -> grant order 0,1,0,1; gnt0 and gnt1 never overlap; each ack goes only to the granted requester.
- req0 pulsed high for one cycle then dropped during ACCESS -> transaction still completes, ack0 pulses once, FSM returns to IDLE.
- reset asserted during WAIT of a read -> next cycle busy=0, gnt0=gnt1=0, no ack issued, prio=0.
- RD_LAT=0 build, req0 read addr=0x07 holding 0x1234 -> rdata=0x1234 with ack0 at grant+2.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
//   Requester 0 (processor): req0, addr0, wdata0, we0 -> gnt0, ack0
//   Requester 1 (loader/IO): req1, addr1, wdata1, we1 -> gnt1, ack1
//   Shared return data:      rdata
//   Memory side:             mem_addr, mem_wdata, mem_we -> mem_rdata
//   Status:                  busy
// slave  : the arbiter's view (requests and memory data in, grants/acks/memory strobes out)
// master : the environment's view (requesters plus memory), mirror of slave
interface mem_bus_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              we0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              we1;
  logic              gnt0;
  logic              gnt1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req0, addr0, wdata0, we0,
    input  req1, addr1, wdata1, we1,
    input  mem_rdata,
    output gnt0, gnt1, ack0, ack1, rdata,
    output mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output req0, addr0, wdata0, we0,
    output req1, addr1, wdata1, we1,
    output mem_rdata,
    input  gnt0, gnt1, ack0, ack1, rdata,
    input  mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a single memory port.
// Requester 0 is the processor datapath, requester 1 the program loader / IO.
// One transaction at a time: IDLE (grant) -> ACCESS -> [WAIT x RD_LAT] -> ACK.
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : mem_bus_arbiter_if.slave (request/grant/ack handshakes, memory port)
// Parameters:
//   DATA_W : data word width
//   ADDR_W : memory address width
//   RD_LAT : memory read latency in cycles (0..7) counted from the address cycle
module mem_bus_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input logic              clock,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

  state_t            state;
  logic              prio;      // requester favoured on a tie
  logic              owner;     // requester holding the current transaction
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic [2:0]        cnt;

  logic              gnt0_q;
  logic              gnt1_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              mem_we_q;
  logic              busy_q;
  logic [DATA_W-1:0] rdata_q;

  logic              any_req;
  logic              pick1;

  // Requester 1 wins when alone, or on a tie when it holds priority.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    pick1   = bus.req1 & (~bus.req0 | prio);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      owner     <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      cnt       <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= pick1;
            lat_addr  <= pick1 ? bus.addr1  : bus.addr0;
            lat_wdata <= pick1 ? bus.wdata1 : bus.wdata0;
            lat_we    <= pick1 ? bus.we1    : bus.we0;
            // Registered outputs take their ACCESS-cycle values here.
            mem_we_q  <= pick1 ? bus.we1    : bus.we0;
            gnt0_q    <= ~pick1;
            gnt1_q    <= pick1;
            busy_q    <= 1'b1;
            state     <= ACCESS;
          end
        end

        ACCESS: begin
          mem_we_q <= 1'b0;
          if (lat_we) begin
            ack0_q <= ~owner;
            ack1_q <= owner;
            state  <= ACK;
          end else if (RD_LAT == 0) begin
            rdata_q <= bus.mem_rdata;
            ack0_q  <= ~owner;
            ack1_q  <= owner;
            state   <= ACK;
          end else begin
            cnt   <= LAT_LOAD;
            state <= WAIT;
          end
        end

        WAIT: begin
          cnt <= cnt - 3'd1;
          // Counter reads 1 in the cycle the memory data becomes valid.
          if (cnt == 3'd1) begin
            rdata_q <= bus.mem_rdata;
            ack0_q  <= ~owner;
            ack1_q  <= owner;
            state   <= ACK;
          end
        end

        ACK: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          gnt0_q <= 1'b0;
          gnt1_q <= 1'b0;
          busy_q <= 1'b0;
          prio   <= ~owner;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.mem_we    = mem_we_q;
  assign bus.busy      = busy_q;

  a_gnt_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(gnt0_q && gnt1_q));

  a_ack_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(ack0_q && ack1_q));

endmodule
